// File: rtl/cpu_pkg.sv
// Shared CPU constants: fetch state encodings, opcode/instruction constants,
// default widths and PC step.
package cpu_pkg;
  localparam int ADDR_W_DEF  = 8;
  localparam int INSTR_W_DEF = 16;
  localparam int PC_STEP     = 2;

  localparam logic [0:0]  FETCH_RUN  = 1'b0;
  localparam logic [0:0]  FETCH_HALT = 1'b1;

  localparam logic [3:0]  HALT_OP   = 4'hF;
  localparam logic [15:0] NOP_INSTR = 16'h0000;
endpackage

// File: rtl/pc_reg.sv
// Fetch PC register: load (word-aligned) > increment by PC_STEP > hold.
module pc_reg
  import cpu_pkg::*;
#(
  parameter int               ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge Clk) begin
    if (Rst)       pc <= RESET_PC;
    else if (load) pc <= {load_addr[ADDR_W-1:1], 1'b0};
    else if (inc)  pc <= pc + ADDR_W'(PC_STEP);
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC, IR latch, stall/redirect/halt handling.
// Optional perf counters (FetchCount, StallCount) under FETCH_PERF_CNT_EN.
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int                 ADDR_W    = ADDR_W_DEF,
  parameter int                 INSTR_W   = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
  parameter logic [3:0]         HALT_OPC  = HALT_OP,
  parameter logic [INSTR_W-1:0] NOP_WORD  = NOP_INSTR
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Stall,
  input  logic               Redirect,
  input  logic [ADDR_W-1:0]  RedirectAddr,
  output logic [ADDR_W-1:0]  MemAddress,
  input  logic [INSTR_W-1:0] MemInstruction,
  output logic [INSTR_W-1:0] IR,
  output logic               IRValid,
  output logic [ADDR_W-1:0]  IRPC,
  output logic               Halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]        FetchCount,
  output logic [15:0]        StallCount
`endif
);

  logic [0:0]        state;
  logic [ADDR_W-1:0] fetch_pc;
  logic              run, latch, stall_run, is_halt;

  assign run       = (state == FETCH_RUN);
  assign latch     = run & ~Redirect & ~Stall;
  assign stall_run = run & ~Redirect & Stall;
  assign is_halt   = (MemInstruction[INSTR_W-1 -: 4] == HALT_OPC);

  // A latched HALT word freezes the PC at the HALT address.
  pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
    .Clk       (Clk),
    .Rst       (Rst),
    .load      (Redirect),
    .load_addr (RedirectAddr),
    .inc       (latch & ~is_halt),
    .pc        (fetch_pc)
  );

  assign MemAddress = fetch_pc;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= FETCH_RUN;
      IR      <= NOP_WORD;
      IRValid <= 1'b0;
      IRPC    <= RESET_PC;
      Halted  <= 1'b0;
    end else begin
      case (state)
        FETCH_RUN: begin
          if (Redirect) begin
            IR      <= NOP_WORD;
            IRValid <= 1'b0;
          end else if (!Stall) begin
            IR      <= MemInstruction;
            IRPC    <= fetch_pc;
            IRValid <= 1'b1;
            if (is_halt) state <= FETCH_HALT;
          end
        end
        FETCH_HALT: begin
          // Halted lags state by one cycle so it rises after IR shows HALT.
          IRValid <= 1'b0;
          if (Redirect) begin
            Halted <= 1'b0;
            state  <= FETCH_RUN;
          end else begin
            Halted <= 1'b1;
          end
        end
        default: state <= FETCH_RUN;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge Clk) begin
    if (Rst) begin
      FetchCount <= '0;
      StallCount <= '0;
    end else begin
      if (latch && FetchCount != 16'hFFFF)     FetchCount <= FetchCount + 16'd1;
      if (stall_run && StallCount != 16'hFFFF) StallCount <= StallCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, hand-written halt/reset
// sequence, then random stimulus against a behavioural model.
module tb_fetch_ctrl;
  logic        Clk = 1'b0;
  logic        Rst = 1'b0, Stall = 1'b0, Redirect = 1'b0;
  logic [7:0]  RedirectAddr = 8'h00;
  logic [7:0]  MemAddress;
  logic [15:0] MemInstruction, IR;
  logic        IRValid, Halted;
  logic [7:0]  IRPC;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] FetchCount, StallCount;
`endif

  logic [15:0] mem [128];
  assign MemInstruction = mem[MemAddress[7:1]];

  always #5 Clk = ~Clk;

  fetch_ctrl dut (
    .Clk(Clk), .Rst(Rst), .Stall(Stall), .Redirect(Redirect),
    .RedirectAddr(RedirectAddr), .MemAddress(MemAddress),
    .MemInstruction(MemInstruction), .IR(IR), .IRValid(IRValid),
    .IRPC(IRPC), .Halted(Halted)
`ifdef FETCH_PERF_CNT_EN
    , .FetchCount(FetchCount), .StallCount(StallCount)
`endif
  );

  int n_vec = 0, n_bad = 0;

  typedef struct {
    logic rst, stall, redir;
    logic [7:0] raddr;
    logic [7:0] ma; logic [15:0] ir; logic v; logic [7:0] irpc; logic h;
  } vec_t;

  function automatic logic [33:0] pack(logic [7:0] ma, logic [15:0] ir,
                                       logic v, logic [7:0] irpc, logic h);
    return {ma, ir, v, irpc, h};
  endfunction

  task automatic check(string name, logic [33:0] act, logic [33:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got MA=%h IR=%h V=%b IRPC=%h H=%b, want MA=%h IR=%h V=%b IRPC=%h H=%b",
               name, act[33:26], act[25:10], act[9], act[8:1], act[0],
               exp[33:26], exp[25:10], exp[9], exp[8:1], exp[0]);
    end
  endtask

  task automatic check16(string name, logic [15:0] act, logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [33:0] outs();
    return {MemAddress, IR, IRValid, IRPC, Halted};
  endfunction

  task automatic step(logic r, logic s, logic d, logic [7:0] a);
    @(negedge Clk);
    Rst = r; Stall = s; Redirect = d; RedirectAddr = a;
    @(posedge Clk);
    #1;
  endtask

  task automatic default_mem();
    for (int i = 0; i < 128; i++) mem[i] = 16'h1000 | 16'(i * 2);
  endtask

  // Behavioural reference state
  logic [7:0]  m_pc, m_irpc;
  logic [15:0] m_ir;
  logic        m_v, m_h, m_halt_state;
  int          m_fc, m_sc;

  task automatic model_step(logic r, logic s, logic d, logic [7:0] a);
    logic [15:0] w;
    if (r) begin
      m_pc = 8'h00; m_ir = 16'h0000; m_v = 0; m_irpc = 8'h00; m_h = 0;
      m_halt_state = 0; m_fc = 0; m_sc = 0;
    end else if (!m_halt_state) begin
      if (d) begin
        m_pc = a & 8'hFE; m_ir = 16'h0000; m_v = 0;
      end else if (s) begin
        if (m_sc < 65535) m_sc++;
      end else begin
        w = mem[m_pc >> 1];
        m_ir = w; m_irpc = m_pc; m_v = 1;
        if (m_fc < 65535) m_fc++;
        if (w[15:12] == 4'hF) m_halt_state = 1;
        else m_pc = 8'((int'(m_pc) + 2) % 256);
      end
    end else begin
      m_v = 0;
      if (d) begin
        m_pc = a & 8'hFE; m_h = 0; m_halt_state = 0;
      end else m_h = 1;
    end
  endtask

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{1,0,0,8'h00, 8'h00,16'h0000,0,8'h00,0};
    tbl[1]  = '{0,0,0,8'h00, 8'h02,16'h1000,1,8'h00,0};
    tbl[2]  = '{0,0,0,8'h00, 8'h04,16'h1002,1,8'h02,0};
    tbl[3]  = '{0,1,0,8'h00, 8'h04,16'h1002,1,8'h02,0};
    tbl[4]  = '{0,1,0,8'h00, 8'h04,16'h1002,1,8'h02,0};
    tbl[5]  = '{0,0,0,8'h00, 8'h06,16'h1004,1,8'h04,0};
    tbl[6]  = '{0,0,1,8'h0B, 8'h0A,16'h0000,0,8'h04,0};
    tbl[7]  = '{0,0,0,8'h00, 8'h0C,16'h100A,1,8'h0A,0};
    tbl[8]  = '{0,1,1,8'hFE, 8'hFE,16'h0000,0,8'h0A,0};
    tbl[9]  = '{0,0,0,8'h00, 8'h00,16'h10FE,1,8'hFE,0};
    tbl[10] = '{0,0,0,8'h00, 8'h02,16'h1000,1,8'h00,0};
    tbl[11] = '{0,1,0,8'h00, 8'h02,16'h1000,1,8'h00,0};
    tbl[12] = '{0,1,0,8'h00, 8'h02,16'h1000,1,8'h00,0};
    tbl[12].rst = 1; tbl[12].ma = 8'h00; tbl[12].ir = 16'h0000;
    tbl[12].v = 0;   tbl[12].irpc = 8'h00;

    default_mem();
    step(1, 0, 0, 8'h00);

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].rst, tbl[i].stall, tbl[i].redir, tbl[i].raddr);
      check($sformatf("vec%0d", i), outs(),
            pack(tbl[i].ma, tbl[i].ir, tbl[i].v, tbl[i].irpc, tbl[i].h));
`ifdef FETCH_PERF_CNT_EN
      if (i == 4) begin
        check16("stall_count", StallCount, 16'd2);
        check16("fetch_count", FetchCount, 16'd2);
      end
`endif
    end

    // Halt word at 08, Stall toggling while halted, redirect out, reset mid-halt
    mem[4] = 16'hF000;
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 8'h00);
    check("pre_halt",   outs(), pack(8'h08, 16'h1006, 1, 8'h06, 0));
    step(0, 0, 0, 8'h00);
    check("halt_latch", outs(), pack(8'h08, 16'hF000, 1, 8'h08, 0));
    step(0, 1, 0, 8'h00);
    check("halted_1",   outs(), pack(8'h08, 16'hF000, 0, 8'h08, 1));
    step(0, 0, 0, 8'h00);
    check("halted_2",   outs(), pack(8'h08, 16'hF000, 0, 8'h08, 1));
    step(0, 1, 0, 8'h00);
    check("halted_3",   outs(), pack(8'h08, 16'hF000, 0, 8'h08, 1));
    step(0, 1, 1, 8'h00);
    check("halt_exit",  outs(), pack(8'h00, 16'hF000, 0, 8'h08, 0));
    step(0, 0, 0, 8'h00);
    check("resume",     outs(), pack(8'h02, 16'h1000, 1, 8'h00, 0));
    step(0, 0, 1, 8'h08);
    check("redir_08",   outs(), pack(8'h08, 16'h0000, 0, 8'h00, 0));
    step(0, 0, 0, 8'h00);
    check("halt_again", outs(), pack(8'h08, 16'hF000, 1, 8'h08, 0));
    step(0, 0, 0, 8'h00);
    check("halted_4",   outs(), pack(8'h08, 16'hF000, 0, 8'h08, 1));
    step(1, 1, 0, 8'h00);
    check("rst_halt",   outs(), pack(8'h00, 16'h0000, 0, 8'h00, 0));

    // Random stimulus vs model
    for (int i = 0; i < 128; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? (16'hF000 | 16'($urandom_range(0, 4095)))
                                           : 16'($urandom_range(0, 16'hEFFF));
    for (int c = 0; c < 800; c++) begin
      logic r, s, d;
      logic [7:0] a;
      r = (c == 0) || ($urandom_range(0, 39) == 0);
      s = ($urandom_range(0, 3) == 0);
      d = ($urandom_range(0, 5) == 0);
      a = 8'($urandom_range(0, 255));
      model_step(r, s, d, a);
      step(r, s, d, a);
      check($sformatf("rnd%0d", c), outs(), pack(m_pc, m_ir, m_v, m_irpc, m_h));
`ifdef FETCH_PERF_CNT_EN
      check16($sformatf("rnd_fc%0d", c), FetchCount, 16'(m_fc));
      check16($sformatf("rnd_sc%0d", c), StallCount, 16'(m_sc));
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Instruction-fetch sequencer for the 256-byte, 16-bit-word instruction memory (8-bit byte Address in, 16-bit Instruction out, combinational read).
- Holds the fetch PC, drives the memory address, and latches the returned word into an instruction register for decode.
- Handles pipeline stall, branch/jump redirect with squash, and a HALT opcode that freezes fetch.
- Sits between inst_mem and the decode/control stage of the CPU.

Parameters:
- ADDR_W, 8, byte-address width; PC step is 2 (one 16-bit word).
- INSTR_W, 16, instruction width.
- RESET_PC, 8'h00, fetch address after reset.
- HALT_OP, 4'hF, opcode value in Instruction[15:12] that halts fetch.
- NOP_INSTR, 16'h0000, value loaded into IR on reset or squash.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Rst  in  1  synchronous reset, active high.
- Stall  in  1  hold IR/PC/FetchPC this cycle.
- Redirect  in  1  taken branch/jump; load RedirectAddr.
- RedirectAddr  in  ADDR_W  new fetch byte address.
- MemAddress  out  ADDR_W  to inst_mem Address; equals FetchPC combinationally.
- MemInstruction  in  INSTR_W  from inst_mem Instruction.
- IR  out  INSTR_W  registered instruction to decode.
- IRValid  out  1  IR holds a real fetched instruction.
- IRPC  out  ADDR_W  byte address IR was fetched from.
- Halted  out  1  fetch frozen by HALT_OP.

Behaviour:
- Reset (Rst=1 at edge, overrides everything, including mid-stall and mid-halt): FetchPC=RESET_PC, IR=NOP_INSTR, IRValid=0, IRPC=RESET_PC, Halted=0, state=RUN.
- Latency: word at FetchPC=A appears on IR, with IRPC=A and IRValid=1, one cycle after MemAddress=A.
- States: RUN, HALT.
- RUN, priority Redirect > Stall > normal:
  - Redirect=1: FetchPC<=RedirectAddr with bit0 forced 0; IR<=NOP_INSTR; IRValid<=0 (squash the in-flight word); IRPC unchanged; Stall ignored.
  - Stall=1, Redirect=0: FetchPC, IR, IRPC, IRValid all hold.
  - Normal: IR<=MemInstruction; IRPC<=FetchPC; IRValid<=1; FetchPC<=FetchPC+2, modulo 2^ADDR_W (8'hFE wraps to 8'h00).
  - If the word being latched has [15:12]==HALT_OP: it is latched normally with IRValid=1, FetchPC does not advance, next state=HALT.
- HALT:
  - Halted=1; IRValid<=0 from the first HALT cycle; IR, IRPC, FetchPC hold; Stall ignored.
  - Redirect=1: FetchPC<=RedirectAddr&~1; Halted<=0; state<=RUN. The first fetch from the target appears on IR the following cycle.
- HALT_OP in MemInstruction while Stall=1 or Redirect=1 is not latched and has no effect.
- Halted is registered and asserts in the same cycle IR shows the HALT instruction plus one.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs FetchCount[15:0] and StallCount[15:0].
  - FetchCount increments on every RUN normal latch.
  - StallCount increments on every RUN cycle with Stall=1 and Redirect=0.
  - Both saturate at 16'hFFFF and clear on Rst.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package cpu_pkg holds:
  - state encodings: FETCH_RUN=1'b0, FETCH_HALT=1'b1;
  - HALT_OP and NOP_INSTR constants;
  - ADDR_W/INSTR_W defaults;
  - PC_STEP=2.
- Optional sub-module pc_reg (FetchPC register with load/increment/hold and bit0 alignment) is natural.
- FSM, IR and counters stay in fetch_ctrl.

Test Plan:
- Sequential fetch: reset, run 6 cycles -> MemAddress 00,02,04,06,08,0A; IRPC trails by one cycle; IRValid=1 from cycle 2.
- Stall on 2 cycles at FetchPC=04 -> MemAddress stays 04; IR/IRPC hold the word from 02; StallCount=2 with FETCH_PERF_CNT_EN.
- Redirect to 8'h0B while FetchPC=06 -> next cycle MemAddress=0A, IRValid=0, IR=NOP_INSTR; following cycle IR=word@0A, IRPC=0A.
- Wrap: Redirect to FE, two normal cycles -> IRPC=FE, then MemAddress=00, then IRPC=00.
- Halt: word 16'hF000 at 08 -> IR=F000 with IRValid=1, then Halted=1, IRValid=0, MemAddress stuck at 08 with Stall toggling; Redirect to 00 -> Halted=0, fetch resumes at 00.
- Reset mid-HALT and mid-Stall -> next cycle all outputs at reset values, MemAddress=RESET_PC.
